spi_slave_ctrl: RTL and testbench
=================================

# spi_slave_ctrl

Protocol engine of the SPI peripheral, directly downstream of the input conditioners. Consumes the conditioned chip-select, conditioned MOSI and the one-cycle SCLK edge pulses; decodes a command byte (address + R/W); performs one write to, or one read from, the peripheral's data memory. Drives MISO and its buffer enable back to the pad.

## Interface
Parameters:
- ADDR_W, 7, address field width; command byte = ADDR_W + 1 bits.
- DATA_W, 8, data byte width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cs_cond  in  1  conditioned chip select, active low.
- sclk_pos  in  1  one-cycle pulse on conditioned SCLK rising edge.
- sclk_neg  in  1  one-cycle pulse on conditioned SCLK falling edge.
- mosi_cond  in  1  conditioned MOSI.
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr.
- mem_addr  out  ADDR_W  latched transaction address.
- mem_wdata  out  DATA_W  byte to write.
- mem_we  out  1  write strobe, one cycle.
- miso  out  1  serial read data, MSB first.
- miso_bufe  out  1  MISO tri-state enable, high only while a read byte is driven.

## Operation
- Mode 0 framing: MOSI sampled on sclk_pos; MISO changes on sclk_neg. MSB first.
- Command byte: bits [7:1] address, bit [0] R/W (1 = read).
- States: IDLE, GET_CMD, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE.
- IDLE -> GET_CMD when cs_cond = 0. Bit counter cleared.
- GET_CMD: shift mosi_cond in on each sclk_pos; after 8th pulse latch mem_addr; -> READ_LOAD if R/W = 1, else WRITE_SHIFT.
- READ_LOAD (1 cycle): load mem_rdata into shift register; miso = bit 7; miso_bufe = 1; -> READ_SHIFT.
- READ_SHIFT: first sclk_neg (end of command byte) ignored; each following sclk_neg shifts left, miso = new MSB; after 8th data sclk_pos -> DONE (or next byte, see Configuration).
- WRITE_SHIFT: shift mosi_cond in on each sclk_pos; after 8th -> WRITE_COMMIT.
- WRITE_COMMIT (1 cycle): mem_we = 1, mem_wdata = assembled byte; -> DONE.
- DONE: ignore all edges until cs_cond = 1.
- Any state: cs_cond = 1 -> IDLE next cycle, miso_bufe = 0, partial write byte discarded (no mem_we).

## Timing
- Reset values: mem_addr = 0, mem_wdata = 0, mem_we = 0, miso = 0, miso_bufe = 0, state IDLE, counter 0.
- Command latch to read byte valid on miso: 1 clk (READ_LOAD).
- 8th write-data sclk_pos to mem_we: 1 clk; mem_we high exactly 1 clk.
- sclk_neg to miso update: 1 clk.
- cs_cond = 1 and sclk_pos in same cycle: CS wins, edge ignored.
- sclk_pos and sclk_neg both high (illegal): sclk_pos processed, sclk_neg ignored.
- reset mid-transaction: reset values next cycle regardless of cs_cond; a low cs_cond then restarts GET_CMD (no resumption).
- Bit counter is 3 bits, wraps 7 -> 0 at byte boundary.

## Configuration
- SPI_AUTOINC_EN defined: after a read or write byte, if cs_cond stays low, mem_addr increments (modulo 2^ADDR_W, 127 -> 0) and the block continues with another data byte of the same direction (READ_LOAD or WRITE_SHIFT) instead of DONE.
- Undefined: exactly one data byte per CS assertion; further edges ignored in DONE.

## Structure
- Package spi_pkg: state enum, ADDR_W/DATA_W defaults, RW_BIT index (0), CMD_W constant.
- One sub-module: spi_shiftreg (DATA_W wide; parallel load, serial-in on sclk_pos enable, serial-out MSB on sclk_neg enable). Controller holds FSM, counter, address register.

## Test plan
- Reset mid-write (cs low, 4 bits shifted) -> all outputs 0, mem_we never pulses.
- Write: cmd 0x0A (addr 0x05, W), data 0xA5 -> mem_we one cycle, mem_addr = 0x05, mem_wdata = 0xA5.
- Read: cmd 0x0B (addr 0x05, R), mem_rdata = 0x3C -> miso_bufe = 1, miso bits 0,0,1,1,1,1,0,0 at successive sclk_pos; miso_bufe = 0 one cycle after cs high.
- CS abort: cmd 0x14 then 5 data bits, cs_cond = 1 -> no mem_we, IDLE next cycle.
- SPI_AUTOINC_EN: write addr 0x7F, data 0x11 then 0x22 under one CS -> writes (0x7F,0x11), (0x00,0x22).
- Without macro: same stimulus -> single write (0x7F,0x11), second byte ignored.

Source files
------------

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//
// Shared definitions for the SPI slave protocol engine: default field widths,
// the position of the read/write flag inside the command byte, and the state
// type used by the controller FSM.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int ADDR_W_DEF = 7;
   localparam int DATA_W_DEF = 8;
   localparam int CMD_W      = ADDR_W_DEF + 1;
   localparam int RW_BIT     = 0;

   typedef enum logic [2:0] {
      IDLE,
      GET_CMD,
      READ_LOAD,
      READ_SHIFT,
      WRITE_SHIFT,
      WRITE_COMMIT,
      DONE
   } spiState_t;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_slave_ctrl_if
//
// Bundles the conditioned SPI pad signals and the data-memory bus of the SPI
// slave protocol engine.
//
// Signals:
//   cs_cond    conditioned chip select, active low
//   sclk_pos   one-cycle pulse on conditioned SCLK rising edge
//   sclk_neg   one-cycle pulse on conditioned SCLK falling edge
//   mosi_cond  conditioned MOSI
//   miso       serial read data, MSB first
//   miso_bufe  MISO tri-state enable
//   mem_addr   latched transaction address
//   mem_wdata  byte to write
//   mem_we     one-cycle write strobe
//   mem_rdata  memory read data, combinational from mem_addr
//
// Modports:
//   slave   the protocol engine's view
//   master  the view of whatever drives the pads and hosts the memory
// ---------------------------------------------------------------------------
interface spi_slave_ctrl_if
   import spi_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              cs_cond;
   logic              sclk_pos;
   logic              sclk_neg;
   logic              mosi_cond;
   logic              miso;
   logic              miso_bufe;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cs_cond, sclk_pos, sclk_neg, mosi_cond, mem_rdata,
      output miso, miso_bufe, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output cs_cond, sclk_pos, sclk_neg, mosi_cond, mem_rdata,
      input  miso, miso_bufe, mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/spi_shiftreg.sv
// ---------------------------------------------------------------------------
// spi_shiftreg
//
// DATA_W-wide data shift register for the SPI slave. Parallel load has
// priority, then serial shift-in (LSB side), then serial shift-out (MSB leaves,
// zero enters). The MSB of o_data is the bit currently presented on MISO.
//
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   i_load        parallel load strobe
//   i_loadData    parallel load value
//   i_shiftInEn   shift i_serialIn in at the LSB
//   i_serialIn    serial input bit
//   i_shiftOutEn  shift towards the MSB, zero fill
//   o_data        register contents
// ---------------------------------------------------------------------------
module spi_shiftreg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_loadData,
   input  logic              i_shiftInEn,
   input  logic              i_serialIn,
   input  logic              i_shiftOutEn,
   output logic [DATA_W-1:0] o_data
);

   logic [DATA_W-1:0] r_data;

   // A single register serves both directions: write bytes are assembled by
   // shifting in, read bytes are loaded whole and then shifted out MSB first.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_loadData;
      end else if (i_shiftInEn) begin
         r_data <= {r_data[DATA_W-2:0], i_serialIn};
      end else if (i_shiftOutEn) begin
         r_data <= {r_data[DATA_W-2:0], 1'b0};
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/spi_slave_ctrl.sv
// ---------------------------------------------------------------------------
// spi_slave_ctrl
//
// SPI mode-0 slave protocol engine. Receives a command byte (address in the
// upper bits, R/W flag in bit 0, 1 = read), then either assembles one write
// byte and strobes it into memory, or fetches one byte from memory and
// shifts it out on MISO, MSB first.
//
// Ports:
//   clk    system clock, all logic on its rising edge
//   reset  synchronous active-high reset
//   bus    spi_slave_ctrl_if.slave (pads + memory bus)
//
// Build option:
//   SPI_AUTOINC_EN  when defined, the address increments after each data byte
//                   and transfers continue in the same direction while chip
//                   select stays low. Otherwise one data byte per CS assertion.
// ---------------------------------------------------------------------------
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic clk,
   input  logic reset,
   spi_slave_ctrl_if.slave bus
);

   localparam int CMD_BITS = ADDR_W + 1;

   spiState_t r_state;
   spiState_t w_next;

   logic [2:0]          r_bitCnt;
   logic [CMD_BITS-2:0] r_cmd;
   logic [ADDR_W-1:0]   r_memAddr;
   logic [DATA_W-1:0]   r_memWdata;
   logic                r_misoBufe;
   logic                r_skipNeg;

   logic [CMD_BITS-1:0] w_cmdFull;
   logic [DATA_W-1:0]   w_shData;
   logic                w_csActive;
   logic                w_pos;
   logic                w_neg;
   logic                w_lastBit;

   logic w_cntClr;
   logic w_cntInc;
   logic w_cmdShift;
   logic w_addrLatch;
   logic w_addrInc;
   logic w_load;
   logic w_shiftIn;
   logic w_shiftOut;
   logic w_wdataLatch;
   logic w_bufeSet;
   logic w_bufeClr;
   logic w_skipSet;
   logic w_skipClr;

   // Edge qualification: chip select high masks every SCLK edge, and a
   // falling-edge pulse coincident with a rising-edge pulse is dropped so
   // the rising edge alone is processed.
   assign w_csActive = ~bus.cs_cond;
   assign w_pos      = bus.sclk_pos & w_csActive;
   assign w_neg      = bus.sclk_neg & ~bus.sclk_pos & w_csActive;
   assign w_lastBit  = (r_bitCnt == 3'd7);
   assign w_cmdFull  = {r_cmd, bus.mosi_cond};

   spi_shiftreg #(.DATA_W(DATA_W)) u_shiftreg (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_load),
      .i_loadData   (bus.mem_rdata),
      .i_shiftInEn  (w_shiftIn),
      .i_serialIn   (bus.mosi_cond),
      .i_shiftOutEn (w_shiftOut),
      .o_data       (w_shData)
   );

   // State register. Reset forces IDLE regardless of chip select, so a
   // transaction interrupted by reset is never resumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and datapath control decode. Chip select going high
   // overrides everything and returns the engine to IDLE; a write byte that
   // has not reached WRITE_COMMIT is simply dropped. In the read path the
   // first falling edge after a byte boundary belongs to the previous byte,
   // so r_skipNeg arms on entry to READ_LOAD and swallows that edge; if the
   // edge lands in the READ_LOAD cycle itself it is consumed right there.
   always_comb begin
      w_next       = r_state;
      w_cntClr     = 1'b0;
      w_cntInc     = 1'b0;
      w_cmdShift   = 1'b0;
      w_addrLatch  = 1'b0;
      w_addrInc    = 1'b0;
      w_load       = 1'b0;
      w_shiftIn    = 1'b0;
      w_shiftOut   = 1'b0;
      w_wdataLatch = 1'b0;
      w_bufeSet    = 1'b0;
      w_bufeClr    = 1'b0;
      w_skipSet    = 1'b0;
      w_skipClr    = 1'b0;

      if (!w_csActive) begin
         w_next    = IDLE;
         w_cntClr  = 1'b1;
         w_bufeClr = 1'b1;
         w_skipClr = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               w_next   = GET_CMD;
               w_cntClr = 1'b1;
            end
            GET_CMD: begin
               if (w_pos) begin
                  w_cmdShift = 1'b1;
                  w_cntInc   = 1'b1;
                  if (w_lastBit) begin
                     w_addrLatch = 1'b1;
                     w_next      = w_cmdFull[RW_BIT] ? READ_LOAD : WRITE_SHIFT;
                  end
               end
            end
            READ_LOAD: begin
               w_load    = 1'b1;
               w_bufeSet = 1'b1;
               w_next    = READ_SHIFT;
               if (w_neg) begin
                  w_skipClr = 1'b1;
               end else begin
                  w_skipSet = 1'b1;
               end
            end
            READ_SHIFT: begin
               if (w_pos) begin
                  w_cntInc = 1'b1;
                  if (w_lastBit) begin
`ifdef SPI_AUTOINC_EN
                     w_addrInc = 1'b1;
                     w_next    = READ_LOAD;
`else
                     w_bufeClr = 1'b1;
                     w_next    = DONE;
`endif
                  end
               end else if (w_neg) begin
                  if (r_skipNeg) begin
                     w_skipClr = 1'b1;
                  end else begin
                     w_shiftOut = 1'b1;
                  end
               end
            end
            WRITE_SHIFT: begin
               if (w_pos) begin
                  w_shiftIn = 1'b1;
                  w_cntInc  = 1'b1;
                  if (w_lastBit) begin
                     w_wdataLatch = 1'b1;
                     w_next       = WRITE_COMMIT;
                  end
               end
            end
            WRITE_COMMIT: begin
`ifdef SPI_AUTOINC_EN
               w_addrInc = 1'b1;
               w_next    = WRITE_SHIFT;
`else
               w_next    = DONE;
`endif
            end
            DONE: begin
               w_next = DONE;
            end
            default: begin
               w_next = IDLE;
            end
         endcase
      end
   end

   // Datapath registers: bit counter (3 bits, wraps naturally at each byte
   // boundary), command history, transaction address, write byte, MISO
   // enable and the skip flag for the stale falling edge. The write byte is
   // captured together with its last bit so it is stable throughout the
   // commit cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bitCnt   <= 3'd0;
         r_cmd      <= '0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_misoBufe <= 1'b0;
         r_skipNeg  <= 1'b0;
      end else begin
         if (w_cntClr) begin
            r_bitCnt <= 3'd0;
         end else if (w_cntInc) begin
            r_bitCnt <= r_bitCnt + 3'd1;
         end

         if (w_cmdShift) begin
            r_cmd <= w_cmdFull[CMD_BITS-2:0];
         end

         if (w_addrLatch) begin
            r_memAddr <= w_cmdFull[CMD_BITS-1 -: ADDR_W];
         end else if (w_addrInc) begin
            r_memAddr <= r_memAddr + ADDR_W'(1);
         end

         if (w_wdataLatch) begin
            r_memWdata <= {w_shData[DATA_W-2:0], bus.mosi_cond};
         end

         if (w_bufeClr) begin
            r_misoBufe <= 1'b0;
         end else if (w_bufeSet) begin
            r_misoBufe <= 1'b1;
         end

         if (w_skipClr) begin
            r_skipNeg <= 1'b0;
         end else if (w_skipSet) begin
            r_skipNeg <= 1'b1;
         end
      end
   end

   // MISO is gated by the buffer enable so that write assembly in the shared
   // shift register never appears on the pad.
   assign bus.mem_addr  = r_memAddr;
   assign bus.mem_wdata = r_memWdata;
   assign bus.mem_we    = (r_state == WRITE_COMMIT);
   assign bus.miso      = w_shData[DATA_W-1] & r_misoBufe;
   assign bus.miso_bufe = r_misoBufe;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_ctrl
//
// Drives SPI mode-0 transactions into spi_slave_ctrl and checks memory writes
// and MISO read bytes against a transaction-level model held in queues.
// Honours SPI_AUTOINC_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_spi_slave_ctrl;
   import spi_pkg::*;

   localparam int AW    = ADDR_W_DEF;
   localparam int DW    = DATA_W_DEF;
   localparam int DEPTH = 1 << AW;

   logic clk;
   logic reset;

   spi_slave_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   spi_slave_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [DW-1:0] memModel [DEPTH];
   assign bus.mem_rdata = memModel[bus.mem_addr];

   logic [AW+DW-1:0] wq [$];
   logic [DW-1:0]    rq [$];

   int vectors     = 0;
   int miscompares = 0;

`ifdef SPI_AUTOINC_EN
   localparam bit AUTO_INC = 1'b1;
`else
   localparam bit AUTO_INC = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Transaction-level model: a command at addr with n data bytes yields
   // n memory accesses at consecutive addresses (mod DEPTH) when address
   // auto-increment is built in, otherwise exactly one.
   task automatic modelExpect(input bit isRead, input logic [AW-1:0] addr,
                              input int n, input logic [3*DW-1:0] wbytes);
      int eff;
      int ai;
      logic [AW-1:0] a;
      eff = AUTO_INC ? n : 1;
      for (int i = 0; i < eff; i++) begin
         ai = (int'(addr) + i) % DEPTH;
         a  = ai[AW-1:0];
         if (isRead) rq.push_back(memModel[a]);
         else        wq.push_back({a, wbytes[DW*i +: DW]});
      end
   endtask

   task automatic sendBit(input logic b, input bit both);
      bus.mosi_cond = b;
      repeat (2) tick();
      bus.sclk_pos = 1'b1;
      if (both) bus.sclk_neg = 1'b1;
      tick();
      bus.sclk_pos = 1'b0;
      bus.sclk_neg = 1'b0;
      repeat (2) tick();
      bus.sclk_neg = 1'b1;
      tick();
      bus.sclk_neg = 1'b0;
   endtask

   task automatic sendByte(input logic [DW-1:0] b, input int bothIdx);
      for (int i = DW - 1; i >= 0; i--) sendBit(b[i], i == bothIdx);
   endtask

   task automatic csLow;
      bus.cs_cond = 1'b0;
      repeat (2) tick();
   endtask

   task automatic csHigh;
      repeat (2) tick();
      bus.cs_cond = 1'b1;
      repeat (3) tick();
   endtask

   task automatic applyStimulus(input bit isRead, input logic [AW-1:0] addr,
                                input int n, input logic [3*DW-1:0] wbytes,
                                input int bothIdx);
      logic [CMD_W-1:0] cmd;
      logic [DW-1:0]    rnd;
      modelExpect(isRead, addr, n, wbytes);
      cmd = {addr, isRead};
      csLow();
      sendByte(cmd, -1);
      for (int i = 0; i < n; i++) begin
         rnd = DW'($urandom);
         sendByte(isRead ? rnd : wbytes[DW*i +: DW], (i == 0) ? bothIdx : -1);
      end
      csHigh();
   endtask

   // Monitor: pops the write queue on every mem_we and the read queue on
   // every complete byte seen on MISO at SCLK rising edges while enabled.
   logic [DW-1:0]    rdShift = '0;
   int               rdCnt   = 0;
   logic             prevWe  = 1'b0;
   logic [AW+DW-1:0] expW;
   logic [DW-1:0]    expR;

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         vectors++;
         if (prevWe) begin
            miscompares++;
            $display("[TB] FAIL memWeWidth: mem_we high 2 cycles, expected 1");
         end else if (wq.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpectedWrite: addr 0x%0h data 0x%0h, expected no write",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            expW = wq.pop_front();
            if ({bus.mem_addr, bus.mem_wdata} !== expW) begin
               miscompares++;
               $display("[TB] FAIL memWrite: addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                        bus.mem_addr, bus.mem_wdata, expW[AW+DW-1:DW], expW[DW-1:0]);
            end
         end
      end
      prevWe = bus.mem_we;

      if (bus.cs_cond || reset) begin
         rdCnt = 0;
      end else if (bus.sclk_pos && bus.miso_bufe) begin
         rdShift = {rdShift[DW-2:0], bus.miso};
         rdCnt++;
         if (rdCnt == DW) begin
            rdCnt = 0;
            vectors++;
            if (rq.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL unexpectedRead: byte 0x%0h, expected none", rdShift);
            end else begin
               expR = rq.pop_front();
               if (rdShift !== expR) begin
                  miscompares++;
                  $display("[TB] FAIL misoByte: got 0x%0h, expected 0x%0h", rdShift, expR);
               end
            end
         end
      end
   end

   initial begin
      logic [AW-1:0]   rAddr;
      logic [3*DW-1:0] rBytes;
      bit              rRead;
      int              rN;

      reset         = 1'b1;
      bus.cs_cond   = 1'b1;
      bus.sclk_pos  = 1'b0;
      bus.sclk_neg  = 1'b0;
      bus.mosi_cond = 1'b0;
      for (int i = 0; i < DEPTH; i++) memModel[i] = DW'($urandom);
      memModel[5] = 8'h3C;

      repeat (3) tick();
      checkOutput("rstMemAddr",  32'(bus.mem_addr),  0);
      checkOutput("rstMemWdata", 32'(bus.mem_wdata), 0);
      checkOutput("rstMemWe",    32'(bus.mem_we),    0);
      checkOutput("rstMiso",     32'(bus.miso),      0);
      checkOutput("rstMisoBufe", 32'(bus.miso_bufe), 0);
      reset = 1'b0;
      repeat (2) tick();

      $display("[TB] reset in the middle of a write");
      csLow();
      sendByte(8'h0A, -1);
      for (int i = 7; i > 3; i--) sendBit(1'(i % 2), 1'b0);
      reset = 1'b1;
      tick();
      checkOutput("midRstMemAddr",  32'(bus.mem_addr),  0);
      checkOutput("midRstMemWdata", 32'(bus.mem_wdata), 0);
      checkOutput("midRstMemWe",    32'(bus.mem_we),    0);
      checkOutput("midRstMiso",     32'(bus.miso),      0);
      checkOutput("midRstMisoBufe", 32'(bus.miso_bufe), 0);
      reset = 1'b0;
      repeat (2) tick();
      modelExpect(1'b0, 7'h05, 1, 24'h0000A5);
      sendByte(8'h0A, -1);
      sendByte(8'hA5, -1);
      csHigh();

      $display("[TB] directed write with coincident SCLK edges");
      applyStimulus(1'b0, 7'h05, 1, 24'h0000A5, 3);

      $display("[TB] directed read of 0x3C");
      modelExpect(1'b1, 7'h05, 1, '0);
      csLow();
      sendByte(8'h0B, -1);
      checkOutput("bufeDuringRead", 32'(bus.miso_bufe), 1);
      sendByte(8'h5A, 3);
      bus.cs_cond = 1'b1;
      tick();
      checkOutput("bufeAfterCs", 32'(bus.miso_bufe), 0);
      checkOutput("misoAfterCs", 32'(bus.miso), 0);
      repeat (3) tick();

      $display("[TB] chip-select abort during write data");
      csLow();
      sendByte(8'h14, -1);
      for (int i = 0; i < 5; i++) sendBit(1'b1, 1'b0);
      bus.cs_cond  = 1'b1;
      bus.sclk_pos = 1'b1;
      tick();
      bus.sclk_pos = 1'b0;
      checkOutput("abortMemWe", 32'(bus.mem_we), 0);
      repeat (3) tick();
      checkOutput("abortMemWeLater", 32'(bus.mem_we), 0);

      $display("[TB] two bytes under one CS from address 0x7F");
      applyStimulus(1'b0, 7'h7F, 2, 24'h002211, -1);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 24; t++) begin
         rAddr  = AW'($urandom_range(0, DEPTH - 1));
         rRead  = 1'($urandom_range(0, 1));
         rN     = $urandom_range(1, 3);
         rBytes = {DW'($urandom), DW'($urandom), DW'($urandom)};
         applyStimulus(rRead, rAddr, rN, rBytes, -1);
      end

      repeat (10) tick();
      checkOutput("writesOutstanding", 32'(wq.size()), 0);
      checkOutput("readsOutstanding",  32'(rq.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
